// File: rtl/sigma_delta_dac_if.sv
// Parallel word input of the sigma-delta DAC.
// Handshake: dv is a one-cycle strobe qualifying d; there is no ready, the
// consumer always accepts and a newer word simply replaces the held one.
interface sigma_delta_dac_if;
  logic [15:0] d;
  logic        dv;

  modport master (output d, output dv);
  modport slave  (input d, input dv);
endinterface

// File: rtl/sigma_delta_dac.sv
// Second-order 1-bit sigma-delta modulator clocked by a divided tick of c.
// Optional LFSR dither into the first integrator: define SIGMA_DELTA_DAC_DITHER_EN.
module sigma_delta_dac #(
  parameter int DIV = 4,
  parameter int IW  = 20
) (
  input  logic             c,
  input  logic             rst_n,
  sigma_delta_dac_if.slave bus,
  input  logic             invert,
  output logic             mod_bit,
  output logic             tick,
  output logic             sat
);
  // Sums carry two guard bits so that clamp detection never sees a wrapped value.
  localparam int AW = IW + 2;
  localparam logic signed [AW-1:0] LIM    = AW'((1 << (IW - 2)) - 1);
  localparam logic signed [AW-1:0] FB_POS = AW'(32768);
  localparam logic signed [AW-1:0] FB_NEG = -FB_POS;

  logic [7:0]           div_cnt;
  logic [15:0]          pend;
  logic signed [IW-1:0] i1;
  logic signed [IW-1:0] i2;
  logic signed [15:0]   x_raw;
  logic signed [15:0]   x_val;
  logic signed [AW-1:0] fb;
  logic signed [AW-1:0] dith;
  logic signed [AW-1:0] i1n;
  logic signed [AW-1:0] i1c;
  logic signed [AW-1:0] i2n;
  logic signed [AW-1:0] i2c;
  logic                 i1_sat;
  logic                 i2_sat;

  function automatic logic signed [AW-1:0] clamp_v(input logic signed [AW-1:0] v);
    if (v > LIM)       return LIM;
    else if (v < -LIM) return -LIM;
    else               return v;
  endfunction

  assign tick = (div_cnt == 8'(DIV - 1));

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 8'd1;
  end

  // A word arriving on a tick cycle is only seen by the following tick.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n)      pend <= 16'h8000;
    else if (bus.dv) pend <= bus.d;
  end

  always_comb begin
    x_raw = {~pend[15], pend[14:0]};
    x_val = x_raw;
    if (invert) x_val = (x_raw == 16'sh8000) ? 16'sh7FFF : -x_raw;
  end

`ifdef SIGMA_DELTA_DAC_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n)    lfsr <= 16'hACE1;
    else if (tick) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // lfsr[2:0] - 4 equals lfsr[2:0] read as 3-bit signed with its top bit flipped.
  assign dith = {{(AW-3){~lfsr[2]}}, ~lfsr[2], lfsr[1:0]};
`else
  assign dith = '0;
`endif

  always_comb begin
    fb     = mod_bit ? FB_POS : FB_NEG;
    i1n    = {{(AW-IW){i1[IW-1]}}, i1} + {{(AW-16){x_val[15]}}, x_val} + dith - fb;
    i1c    = clamp_v(i1n);
    i2n    = {{(AW-IW){i2[IW-1]}}, i2} + i1c - fb;
    i2c    = clamp_v(i2n);
    i1_sat = (i1c != i1n);
    i2_sat = (i2c != i2n);
  end

  assign sat = tick & (i1_sat | i2_sat);

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      i1      <= '0;
      i2      <= '0;
      mod_bit <= 1'b0;
    end else if (tick) begin
      i1      <= i1c[IW-1:0];
      i2      <= i2c[IW-1:0];
      mod_bit <= ~i2c[AW-1];
    end
  end
endmodule

// File: tb/tb_sigma_delta_dac.sv
// Bench for sigma_delta_dac: a reference model pushes each expected output bit
// to a queue on the tick cycle; the bit is popped and compared one cycle later.
module tb_sigma_delta_dac;
  localparam int DIV = 4;
  localparam int IW  = 20;
  localparam int LIM = (1 << (IW - 2)) - 1;

  logic c;
  logic rst_n;
  logic invert;
  logic mod_bit;
  logic tick;
  logic sat;

  sigma_delta_dac_if bus ();

  sigma_delta_dac #(.DIV(DIV), .IW(IW)) dut (
    .c       (c),
    .rst_n   (rst_n),
    .bus     (bus),
    .invert  (invert),
    .mod_bit (mod_bit),
    .tick    (tick),
    .sat     (sat)
  );

  // clock / reset
  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:0] exp_q[$];
  logic       pop_pending;

  int          m_cnt;
  int          m_i1;
  int          m_i2;
  logic        m_bit;
  logic [15:0] m_pend;
  logic [15:0] m_lfsr;

  int   win_ones;
  int   win_ticks;
  int   sat_seen;
  int   range_bad;
  int   eq_adj;
  logic last_bit;
  logic have_last;
  logic obs_tick;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int v);
    if (v > LIM)  return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  function automatic int dither_of(input logic [15:0] l);
`ifdef SIGMA_DELTA_DAC_DITHER_EN
    return int'(l[2:0]) - 4;
`else
    return 0 * int'(l[0]);
`endif
  endfunction

  task automatic win_reset();
    win_ones  = 0;
    win_ticks = 0;
    sat_seen  = 0;
    range_bad = 0;
    eq_adj    = 0;
    have_last = 1'b0;
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_i1   = 0;
    m_i2   = 0;
    m_bit  = 1'b0;
    m_pend = 16'h8000;
    m_lfsr = 16'hACE1;
    exp_q.delete();
    pop_pending = 1'b0;
    win_reset();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    bus.dv = 1'b0;
    bus.d  = 16'h0000;
    invert = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge c);
      #1;
      check_eq("rst_mod_bit", mod_bit, 1'b0);
      check_eq("rst_tick", tick, 1'b0);
      check_eq("rst_sat", sat, 1'b0);
    end
    @(negedge c);
    rst_n = 1'b1;
  endtask

  // driver: one clock cycle, called at a falling edge
  task automatic run_cycle(input logic dv_i, input logic [15:0] d_i);
    int   x;
    int   fb;
    int   i1n;
    int   c1;
    int   i2n;
    int   c2;
    int   a1;
    int   a2;
    logic exp_tick;
    logic exp_sat;
    logic [0:0] exp_bit;
    bus.dv = dv_i;
    bus.d  = d_i;
    #1;
    exp_tick = (m_cnt == DIV - 1);
    obs_tick = tick;
    check_eq("tick", tick, exp_tick);
    if (pop_pending) begin
      exp_bit = exp_q.pop_front();
      check_eq("mod_bit", mod_bit, exp_bit);
      win_ticks++;
      if (mod_bit) win_ones++;
      if (have_last && (mod_bit == last_bit)) eq_adj++;
      last_bit    = mod_bit;
      have_last   = 1'b1;
      pop_pending = 1'b0;
    end
    x = int'(m_pend) - 32768;
    if (invert) x = (x == -32768) ? 32767 : -x;
    fb  = m_bit ? 32768 : -32768;
    i1n = m_i1 + x - fb + dither_of(m_lfsr);
    c1  = clampi(i1n);
    i2n = m_i2 + c1 - fb;
    c2  = clampi(i2n);
    exp_sat = exp_tick && ((c1 != i1n) || (c2 != i2n));
    check_eq("sat", sat, exp_sat);
    if (sat) sat_seen++;
    if (exp_tick) begin
      a1 = dut.i1;
      a2 = dut.i2;
      check_eq("i1", a1, m_i1);
      check_eq("i2", a2, m_i2);
      if (a1 > LIM || a1 < -LIM || a2 > LIM || a2 < -LIM) range_bad++;
`ifdef SIGMA_DELTA_DAC_DITHER_EN
      check_eq("lfsr", dut.lfsr, m_lfsr);
`endif
      exp_q.push_back(c2 >= 0);
      pop_pending = 1'b1;
    end
    @(posedge c);
    if (exp_tick) begin
      m_i1   = c1;
      m_i2   = c2;
      m_bit  = (c2 >= 0);
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_cnt  = 0;
    end else begin
      m_cnt++;
    end
    if (dv_i) m_pend = d_i;
    @(negedge c);
  endtask

  // run until n more output bits have been scored in the current window
  task automatic run_bits(input int n);
    int target;
    target = win_ticks + n;
    for (int k = 0; k < (n + 2) * DIV && win_ticks < target; k++) run_cycle(1'b0, 16'h0000);
    check_eq("bits_reached", win_ticks, target);
  endtask

  task automatic goto_tick_cycle();
    for (int k = 0; k < DIV && m_cnt != DIV - 1; k++) run_cycle(1'b0, 16'h0000);
  endtask

  logic [15:0] dens_d[3]   = '{16'hC000, 16'h4000, 16'hC000};
  logic        dens_inv[3] = '{1'b0, 1'b0, 1'b1};
  int          dens_tgt[3] = '{192, 64, 64};

  initial begin
    int p_i1;
    int p_fb;
    int p_dth;
    int obs;

    // reset and tick cadence
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b0, 16'h0000);
      check_eq($sformatf("tick_cycle%0d", i), obs_tick, ((i % DIV) == DIV - 1));
    end

    // mid-scale, no input word
    do_reset();
    run_bits(16);
    win_reset();
    run_bits(256);
`ifndef SIGMA_DELTA_DAC_DITHER_EN
    check_eq("mid_ones", win_ones, 128);
    check_eq("mid_sat", sat_seen, 0);
`endif

    // density for a few input levels and polarity
    for (int t = 0; t < 3; t++) begin
      do_reset();
      invert = dens_inv[t];
      run_cycle(1'b1, dens_d[t]);
      run_bits(32);
      win_reset();
      run_bits(256);
      check_eq($sformatf("dens_%h_inv%0d_ones%0d", dens_d[t], dens_inv[t], win_ones),
               (win_ones >= dens_tgt[t] - 2) && (win_ones <= dens_tgt[t] + 2), 1'b1);
    end

    // positive full scale held for 1000 ticks
    do_reset();
    run_cycle(1'b1, 16'hFFFF);
    run_bits(744);
    check_eq("fs_sat_pulsed", sat_seen > 0, 1'b1);
    check_eq("fs_range_early", range_bad, 0);
    win_reset();
    run_bits(256);
    check_eq($sformatf("fs_ones%0d", win_ones), win_ones >= 250, 1'b1);
    check_eq("fs_range_late", range_bad, 0);

    // word strobed on a tick cycle is used one tick later
    do_reset();
    run_bits(20);
    goto_tick_cycle();
    p_i1  = m_i1;
    p_fb  = m_bit ? 32768 : -32768;
    p_dth = dither_of(m_lfsr);
    run_cycle(1'b1, 16'hFFFF);
    obs = dut.i1;
    check_eq("dvtick_uses_old", obs, p_i1 + 0 - p_fb + p_dth);
    goto_tick_cycle();
    p_i1  = m_i1;
    p_fb  = m_bit ? 32768 : -32768;
    p_dth = dither_of(m_lfsr);
    run_cycle(1'b0, 16'h0000);
    obs = dut.i1;
    check_eq("dvtick_next_new", obs, p_i1 + 32767 - p_fb + p_dth);

    // asynchronous reset in the middle of a stream
    do_reset();
    run_cycle(1'b1, 16'hFFFF);
    run_bits(10);
    check_eq("pre_arst_bit", mod_bit, m_bit);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_mod_bit", mod_bit, 1'b0);
    check_eq("arst_tick", tick, 1'b0);
    check_eq("arst_sat", sat, 1'b0);
    obs = dut.i1;
    check_eq("arst_i1", obs, 0);
    obs = dut.i2;
    check_eq("arst_i2", obs, 0);
    do_reset();
    run_bits(8);

`ifdef SIGMA_DELTA_DAC_DITHER_EN
    // dithered mid-scale
    do_reset();
    run_bits(1024);
    check_eq($sformatf("dith_ones%0d", win_ones), (win_ones >= 504) && (win_ones <= 520), 1'b1);
    check_eq("dith_not_alternating", eq_adj > 0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
